// File: rtl/multiaddr_fork_if.sv
// Bundle of upstream request and per-port downstream signals for multiaddr_fork.
// Ports (signals):
//   valid_i/ready_o            upstream handshake
//   data_i, select_i           payload and decoded target vector
//   addr_i, mask_i             per-port decoded address/mask, port k at [k*AddrWidth +: AddrWidth]
//   dec_error_i                decoder found no matching rule
//   valid_o/ready_i            per-port downstream handshake
//   data_o, addr_o, mask_o     held payload and per-port address/mask
//   err_o, busy_o              drop pulse and fork-outstanding status
// Modports: slave = the fork itself, master = the environment driving it.
interface multiaddr_fork_if #(
    parameter int unsigned NoOutputs = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                           valid_i;
    logic                           ready_o;
    logic [DataWidth-1:0]           data_i;
    logic [NoOutputs-1:0]           select_i;
    logic [NoOutputs*AddrWidth-1:0] addr_i;
    logic [NoOutputs*AddrWidth-1:0] mask_i;
    logic                           dec_error_i;
    logic [NoOutputs-1:0]           valid_o;
    logic [NoOutputs-1:0]           ready_i;
    logic [DataWidth-1:0]           data_o;
    logic [NoOutputs*AddrWidth-1:0] addr_o;
    logic [NoOutputs*AddrWidth-1:0] mask_o;
    logic                           err_o;
    logic                           busy_o;

    modport slave (
        input  valid_i, data_i, select_i, addr_i, mask_i, dec_error_i, ready_i,
        output ready_o, valid_o, data_o, addr_o, mask_o, err_o, busy_o
    );

    modport master (
        output valid_i, data_i, select_i, addr_i, mask_i, dec_error_i, ready_i,
        input  ready_o, valid_o, data_o, addr_o, mask_o, err_o, busy_o
    );
endinterface

// File: rtl/multiaddr_fork.sv
// Forks one decoded request to every selected downstream port. Each selected port gets its
// own valid and completes independently; the upstream is released once all have completed.
// Requests with a decode error or an empty select vector are accepted and dropped, flagged
// by a one-cycle err_o pulse.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus     multiaddr_fork_if.slave (upstream request in, per-port requests out)
module multiaddr_fork #(
    parameter int unsigned NoOutputs = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multiaddr_fork_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StFork} state_e;

    state_e                         r_state;
    state_e                         w_state_d;
    logic [NoOutputs-1:0]           r_pending;
    logic [NoOutputs-1:0]           w_pending_d;
    logic [DataWidth-1:0]           r_data;
    logic [NoOutputs*AddrWidth-1:0] r_addr;
    logic [NoOutputs*AddrWidth-1:0] r_mask;
    logic                           r_err;

    logic [NoOutputs-1:0]           w_out_hs;
    logic                           w_done;
    logic                           w_ready;
    logic                           w_in_hs;
    logic                           w_accept;

    // Handshake decode. valid_o comes straight from r_pending, so ready_i only feeds ready_o.
    always_comb begin
        w_out_hs = r_pending & bus.ready_i;
        w_done   = ((r_pending & ~w_out_hs) == '0);
        w_ready  = (r_state == StIdle) || ((r_state == StFork) && w_done);
        w_in_hs  = bus.valid_i && w_ready;
        w_accept = w_in_hs && !bus.dec_error_i && (bus.select_i != '0);
    end

    always_comb begin
        w_state_d   = r_state;
        w_pending_d = r_pending & ~w_out_hs;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_d = StFork;
            end
            StFork: begin
                // A new request landing on the completion cycle keeps us in StFork.
                if (w_accept)    w_state_d = StFork;
                else if (w_done) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        if (w_accept) w_pending_d = bus.select_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_pending <= '0;
            r_data    <= '0;
            r_addr    <= '0;
            r_mask    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pending <= w_pending_d;
            r_err     <= w_in_hs && !w_accept;
            if (w_accept) begin
                r_data <= bus.data_i;
                r_addr <= bus.addr_i;
                r_mask <= bus.mask_i;
            end
        end
    end

    assign bus.ready_o = w_ready;
    assign bus.valid_o = r_pending;
    assign bus.data_o  = r_data;
    assign bus.addr_o  = r_addr;
    assign bus.mask_o  = r_mask;
    assign bus.err_o   = r_err;
    assign bus.busy_o  = (r_state == StFork);

endmodule

// File: tb/tb_multiaddr_fork.sv
// Scoreboard bench for multiaddr_fork: per-port queues of owed requests, filled when the
// model accepts a request and drained by a monitor on downstream handshakes.
module tb_multiaddr_fork;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [AW-1:0] mask;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiaddr_fork_if #(.NoOutputs(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

    multiaddr_fork #(.NoOutputs(N), .AddrWidth(AW), .DataWidth(DW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    item_t       exp_q [N][$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        exp_err  = 1'b0;
    logic        m_ready  = 1'b1;
    int          hs_port0 = 0;
    logic [N-1:0] ev;
    logic        er;
    item_t       it;
    item_t       nw;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Monitor: compare outputs against the owed-request queues, pop on downstream handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            ev = '0;
            er = 1'b1;
            for (int k = 0; k < N; k++) begin
                ev[k] = (exp_q[k].size() != 0);
                if (ev[k] && !bus.ready_i[k]) er = 1'b0;
            end
            m_ready = er;
            check("valid_o", 64'(bus.valid_o), 64'(ev));
            check("ready_o", 64'(bus.ready_o), 64'(er));
            check("busy_o", 64'(bus.busy_o), 64'(|ev));
            check("err_o", 64'(bus.err_o), 64'(exp_err));
            for (int k = 0; k < N; k++) begin
                if (ev[k]) begin
                    it = exp_q[k][0];
                    check("data_o", 64'(bus.data_o), 64'(it.data));
                    check("addr_o", 64'(bus.addr_o[k*AW +: AW]), 64'(it.addr));
                    check("mask_o", 64'(bus.mask_o[k*AW +: AW]), 64'(it.mask));
                    if (bus.ready_i[k]) begin
                        void'(exp_q[k].pop_front());
                        if (k == 0) hs_port0++;
                    end
                end
            end
        end
    end

    // Model of the upstream side: on an accepted handshake, owe the request to each selected port.
    always @(negedge clk) begin
        #1;
        exp_err = 1'b0;
        if (!rst && bus.valid_i && m_ready) begin
            if (bus.dec_error_i || bus.select_i == '0) begin
                exp_err = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (bus.select_i[k]) begin
                        nw.data = bus.data_i;
                        nw.addr = bus.addr_i[k*AW +: AW];
                        nw.mask = bus.mask_i[k*AW +: AW];
                        exp_q[k].push_back(nw);
                    end
                end
            end
        end
    end

    // Apply one cycle of inputs (called just after a rising edge), then advance a cycle.
    task automatic step(input logic v, input logic [N-1:0] sel, input logic de,
                        input logic [N-1:0] rdy, input logic [DW-1:0] d);
        bus.valid_i     = v;
        bus.select_i    = sel;
        bus.dec_error_i = de;
        bus.ready_i     = rdy;
        bus.data_i      = d;
        bus.addr_i      = {$urandom, $urandom};
        bus.mask_i      = {$urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h0;
        int left;
        rst             = 1'b1;
        bus.valid_i     = 1'b0;
        bus.select_i    = '0;
        bus.dec_error_i = 1'b0;
        bus.ready_i     = '0;
        bus.data_i      = '0;
        bus.addr_i      = '0;
        bus.mask_i      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_o", 64'(bus.valid_o), 64'(0));
        check("rst_busy_o", 64'(bus.busy_o), 64'(0));
        check("rst_err_o", 64'(bus.err_o), 64'(0));
        check("rst_data_o", 64'(bus.data_o), 64'(0));
        check("rst_addr_o", 64'(bus.addr_o), 64'(0));
        check("rst_mask_o", 64'(bus.mask_o), 64'(0));
        rst = 1'b0;
        #1;
        check("rst_ready_o", 64'(bus.ready_o), 64'(1));

        // Fan-out to three ports, all ready.
        step(1'b1, 4'b1011, 1'b0, 4'hF, 32'hA5A5_0001);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);

        // Port 2 stalls; a second request waits upstream and is taken on the completion cycle.
        step(1'b1, 4'b0110, 1'b0, 4'b0010, 32'hB0B0_0002);
        step(1'b1, 4'b1001, 1'b0, 4'b0010, 32'hC0C0_0003);
        step(1'b1, 4'b1001, 1'b0, 4'b0010, 32'hC0C0_0003);
        step(1'b1, 4'b1001, 1'b0, 4'b0010, 32'hC0C0_0003);
        step(1'b1, 4'b1001, 1'b0, 4'b0110, 32'hC0C0_0003);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);

        // Dropped requests: decode error, then empty select.
        step(1'b1, 4'b0101, 1'b1, 4'hF, 32'hDEAD_0004);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b1, 4'b0000, 1'b0, 4'hF, 32'hDEAD_0005);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);

        // Back-to-back on port 0.
        h0 = hs_port0;
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0001, 1'b0, 4'hF, 32'(100 + i));
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        check("b2b_port0_count", 64'(hs_port0 - h0), 64'(8));

        // Reset while holding a request for ports 2 and 3.
        step(1'b1, 4'b1100, 1'b0, 4'b0000, 32'h1234_5678);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 32'h0);
        check("pre_rst_valid_o", 64'(bus.valid_o), 64'(4'b1100));
        #1;
        rst = 1'b1;
        for (int k = 0; k < N; k++) exp_q[k].delete();
        #1;
        check("async_rst_valid_o", 64'(bus.valid_o), 64'(0));
        check("async_rst_busy_o", 64'(bus.busy_o), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready_o", 64'(bus.ready_o), 64'(1));
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);

        // Random stall stress.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 7) == 0),
                 4'($urandom), $urandom);
        end

        // Drain everything still owed.
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 1'b0, 4'hF, 32'h0);
        left = 0;
        for (int k = 0; k < N; k++) left += exp_q[k].size();
        check("drain_empty", 64'(left), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
